mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified instruction/data memory of the multicycle core between two requesters: the CPU datapath, with fetch and load/store cycles sequenced by the control unit, and the boot/debug loader that writes program images. Each access is a single-beat transaction. A latency counter paces each access, and a registered response is returned to the owner. The CPU controller stalls its FSM while its request is pending.

## Interface
- `WIDTH`, 32: data width
- `ADDR_W`, 10: word-address width
- `MEM_LAT`, 1: memory read latency in cycles (≥1)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `cpu_req`, `cpu_we`  in  1  CPU request / write enable
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  WIDTH  CPU write data
- `cpu_gnt`  out  1  CPU request accepted this cycle
- `cpu_rvalid`  out  1  CPU response/ack, one-cycle pulse
- `cpu_rdata`  out  WIDTH  CPU read data, registered
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_rvalid`, `ldr_rdata`: same as the CPU set, for the loader
- `ldr_lock`  in  1  loader holds exclusive ownership; CPU denied
- `mem_en`, `mem_we`  out  1  memory strobe / write
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  WIDTH; `mem_rdata`  in  WIDTH
- `busy`  out  1  an access is in flight

## Operation
- FSM states are IDLE and WAIT.
- **IDLE**
  - Arbitration runs only in IDLE.
  - On a winner, that requester's `gnt`, `mem_en`, and `mem_we`/`mem_addr`/`mem_wdata` are driven combinationally from the winner in the same cycle. The FSM then moves to WAIT and the counter loads `MEM_LAT`.
- **Eligibility**
  - The CPU is eligible when `cpu_req & ~ldr_lock`.
  - The loader is eligible when `ldr_req`.
- **Winner choice:** fixed priority, CPU first. The Configuration section changes this rule.
- **WAIT**
  - The counter decrements each cycle.
  - When the counter is 1, `mem_rdata` is captured into the owner's `rdata` for reads only; a write leaves `rdata` unchanged. `rvalid` is set for the next cycle, and the FSM returns to IDLE.
- **Requester rules**
  - A requester holds `req` and all attributes stable until it sees `gnt`.
  - Attributes are sampled only in the grant cycle.
  - Dropping `req` before grant cancels the request with no side effects.
- **Outputs when not granting:** `mem_*` outputs are all 0 outside a grant cycle; `gnt` is never high outside IDLE.
- **`ldr_lock` timing**
  - `ldr_lock` asserted during WAIT of a CPU access does not abort that access. It blocks only later CPU grants.
  - Deasserting `ldr_lock` makes the CPU eligible in the same cycle.
- **`busy`** = (state == WAIT).
- **Reset**
  - All outputs are 0; state is IDLE and the counter is 0.
  - `rdata` registers clear to 0, and the RR pointer is set to "last = loader".
  - A reset during WAIT discards the access, and no `rvalid` is produced.

## Timing
- Accept at cycle T (`gnt`=1, `mem_en`=1).
- `mem_rdata` is valid at T+`MEM_LAT`.
- `rvalid` and `rdata` are valid at T+`MEM_LAT`+1.
- The next grant is possible at T+`MEM_LAT`+1, the same cycle as `rvalid`.
- Peak throughput is one access per `MEM_LAT`+1 cycles.
- Write ack (`rvalid`) uses identical timing.
- With `MEM_LAT`=1: grant at T, WAIT at T+1, `rvalid` at T+2.

## Configuration
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- **Defined:** when both requesters are eligible in IDLE, the winner is the one not granted last.
  - The pointer updates on every grant.
  - A single eligible requester always wins.
  - `ldr_lock` still overrides.
- **Undefined:** fixed CPU priority. The pointer register is not instantiated.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE, WAIT);
  - the owner encoding (OWN_CPU=0, OWN_LDR=1);
  - the default `MEM_LAT` constant.
- One sub-module, `mem_arb_lat_cnt`: a loadable down-counter of width `$clog2(MEM_LAT+1)` with a `done` (count==1) output.
- Arbitration, owner register, response registers, and FSM live in the top module.

## Test plan
- **CPU read, `MEM_LAT`=1:** `cpu_req`=1, addr 0x004, `mem_rdata`=0xDEADBEEF at T+1 -> `cpu_gnt` at T, `cpu_rvalid`=1 and `cpu_rdata`=0xDEADBEEF at T+2 only.
- **Simultaneous requests**
  - Both `req` held high for 4 accesses.
  - Fixed build: 4 CPU grants.
  - RR build: order CPU, LDR, CPU, LDR.
- **Lock**
  - `ldr_lock`=1 with both requesting: only loader grants.
  - Lock dropped: CPU granted in the next IDLE cycle.
- **Loader write**
  - Loader write 0x0000_0020 to 0x010: `mem_we`=1, `mem_addr`=0x010 in the grant cycle.
  - `ldr_rvalid` pulses 2 cycles later.
  - `ldr_rdata` is unchanged.
- **Reset mid-WAIT:** `rst` during WAIT -> next cycle state IDLE, all outputs 0, no `rvalid`, and a new request is granted immediately after reset.
- **`MEM_LAT`=3:** back-to-back CPU reads -> grants spaced 4 cycles apart, `rvalid` at T+4.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_e;

    typedef enum logic {
        OwnCpu = 1'b0,
        OwnLdr = 1'b1
    } owner_e;

    localparam int unsigned MEM_LAT_DEFAULT = 1;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter that paces one memory access; done flags the final WAIT cycle.
module mem_arb_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT,
    localparam int unsigned CW = $clog2(MEM_LAT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam logic [CW-1:0] LoadVal = CW'(MEM_LAT);

    logic [CW-1:0] count_q;

    // Load on grant, then count down to zero and hold there.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= LoadVal;
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign done = (count_q == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU, loader) arbiter for the single-ported unified memory.
// Define MEM_ARB_ROUND_ROBIN_EN to break CPU/loader ties round-robin instead
// of by fixed CPU priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WIDTH-1:0]  cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [WIDTH-1:0]  cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [WIDTH-1:0]  ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [WIDTH-1:0]  ldr_rdata,
    input  logic              ldr_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              busy
);

    state_e           state_q, state_d;
    owner_e           owner_q;
    logic             we_q;
    logic             cpu_elig, ldr_elig, pick_cpu, grant, lat_done;
    logic             cpu_rvalid_q, ldr_rvalid_q;
    logic [WIDTH-1:0] cpu_rdata_q, ldr_rdata_q;

    assign cpu_elig = cpu_req & ~ldr_lock;
    assign ldr_elig = ldr_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e last_q;

    // On a tie the side not granted last wins; a lone eligible side always wins.
    assign pick_cpu = cpu_elig & (~ldr_elig | (last_q == OwnLdr));

    // Remember which requester received the most recent grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OwnLdr;
        end else if (grant) begin
            last_q <= pick_cpu ? OwnCpu : OwnLdr;
        end
    end
`else
    assign pick_cpu = cpu_elig;
`endif

    // Next state plus the combinational grant-cycle memory strobe.
    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        cpu_gnt   = 1'b0;
        ldr_gnt   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            StIdle: begin
                // Reset is synchronous, so a grant here would be lost; suppress it.
                if (!rst && (cpu_elig || ldr_elig)) begin
                    grant   = 1'b1;
                    state_d = StWait;
                    mem_en  = 1'b1;
                    if (pick_cpu) begin
                        cpu_gnt   = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                    end else begin
                        ldr_gnt   = 1'b1;
                        mem_we    = ldr_we;
                        mem_addr  = ldr_addr;
                        mem_wdata = ldr_wdata;
                    end
                end
            end
            StWait: begin
                if (lat_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register plus owner/direction of the access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= OwnCpu;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= pick_cpu ? OwnCpu : OwnLdr;
                we_q    <= pick_cpu ? cpu_we : ldr_we;
            end
        end
    end

    // Registered response: read data captured on the last WAIT cycle, ack pulse after.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            if (state_q == StWait && lat_done) begin
                if (owner_q == OwnCpu) begin
                    cpu_rvalid_q <= 1'b1;
                    if (!we_q) begin
                        cpu_rdata_q <= mem_rdata;
                    end
                end else begin
                    ldr_rvalid_q <= 1'b1;
                    if (!we_q) begin
                        ldr_rdata_q <= mem_rdata;
                    end
                end
            end
        end
    end

    mem_arb_lat_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (grant),
        .done (lat_done)
    );

    assign cpu_rvalid = cpu_rvalid_q;
    assign ldr_rvalid = ldr_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign ldr_rdata  = ldr_rdata_q;
    assign busy       = (state_q == StWait) & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiter instances (MEM_LAT 1 and 3) driven by random
// protocol-correct requesters and compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned NCYC   = 800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One requester step: a grant retires the request; while not granted it may
    // cancel; when free it picks new attributes and may start a request.
    task automatic next_req(input bit granted, input bit hammer, inout bit act,
                            inout logic we, inout logic [ADDR_W-1:0] addr,
                            inout logic [WIDTH-1:0] wd);
        if (granted) begin
            act = 1'b0;
        end else if (act && !hammer && $urandom_range(0, 15) == 0) begin
            act = 1'b0;
        end
        if (!act) begin
            we   = 1'($urandom_range(0, 1));
            addr = ADDR_W'($urandom);
            wd   = $urandom;
            act  = hammer || ($urandom_range(0, 2) == 0);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_cfg
        localparam int unsigned LAT = (g == 0) ? 1 : 3;

        logic              rst, cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
        logic [ADDR_W-1:0] cpu_addr, ldr_addr, mem_addr;
        logic [WIDTH-1:0]  cpu_wdata, ldr_wdata, mem_wdata, mem_rdata, cpu_rdata, ldr_rdata;
        logic              cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_en, mem_we, busy;
        bit                fin = 1'b0;

        mem_port_arbiter #(
            .WIDTH   (WIDTH),
            .ADDR_W  (ADDR_W),
            .MEM_LAT (LAT)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .cpu_req    (cpu_req),
            .cpu_we     (cpu_we),
            .cpu_addr   (cpu_addr),
            .cpu_wdata  (cpu_wdata),
            .cpu_gnt    (cpu_gnt),
            .cpu_rvalid (cpu_rvalid),
            .cpu_rdata  (cpu_rdata),
            .ldr_req    (ldr_req),
            .ldr_we     (ldr_we),
            .ldr_addr   (ldr_addr),
            .ldr_wdata  (ldr_wdata),
            .ldr_gnt    (ldr_gnt),
            .ldr_rvalid (ldr_rvalid),
            .ldr_rdata  (ldr_rdata),
            .ldr_lock   (ldr_lock),
            .mem_en     (mem_en),
            .mem_we     (mem_we),
            .mem_addr   (mem_addr),
            .mem_wdata  (mem_wdata),
            .mem_rdata  (mem_rdata),
            .busy       (busy)
        );

        initial begin : run
            // requester state
            bit                c_act, l_act, c_gp, l_gp, hammer, lock;
            logic              c_we, l_we;
            logic [ADDR_W-1:0] c_addr, l_addr;
            logic [WIDTH-1:0]  c_wd, l_wd;
            // reference model: access timeline in cycle numbers
            int                free_at, cap_at, w;
            bit                pend, p_ldr, p_we, last_ldr, known, ce, le;
            bit                exp_rv [2];
            logic [WIDTH-1:0]  exp_rd [2];
            logic              e_we;
            logic [ADDR_W-1:0] e_addr;
            logic [WIDTH-1:0]  e_wd;
            string             pfx;

            c_act = 1'b0; l_act = 1'b0; c_gp = 1'b0; l_gp = 1'b0; lock = 1'b0;
            c_we = 1'b0; l_we = 1'b0; c_addr = '0; l_addr = '0; c_wd = '0; l_wd = '0;
            free_at = 0; cap_at = 0; pend = 1'b0; p_ldr = 1'b0; p_we = 1'b0;
            last_ldr = 1'b1; known = 1'b0;
            exp_rv[0] = 1'b0; exp_rv[1] = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0;
            rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
            ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
            ldr_lock = 1'b0; mem_rdata = '0;

            for (int n = 0; n < int'(NCYC); n++) begin
                @(posedge clk);
                #1;
                // Phases: reset, both hammering, both hammering under lock,
                // lock released, then fully random traffic with occasional reset.
                hammer = (n >= 3 && n < 120);
                if (n >= 50 && n < 90) lock = 1'b1;
                else if (n < 120) lock = 1'b0;
                else if ($urandom_range(0, 7) == 0) lock = ~lock;
                rst = (n < 3) || (n >= 150 && $urandom_range(0, 39) == 0);
                next_req(c_gp, hammer, c_act, c_we, c_addr, c_wd);
                next_req(l_gp, hammer, l_act, l_we, l_addr, l_wd);
                cpu_req = c_act; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
                ldr_req = l_act; ldr_we = l_we; ldr_addr = l_addr; ldr_wdata = l_wd;
                ldr_lock = lock;
                mem_rdata = $urandom;

                @(negedge clk);
                // Winner this cycle: none while in flight or in reset.
                w = -1;
                if (!rst && n >= free_at) begin
                    ce = cpu_req && !ldr_lock;
                    le = ldr_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (ce && le) w = last_ldr ? 0 : 1;
                    else if (ce) w = 0;
                    else if (le) w = 1;
`else
                    if (ce) w = 0;
                    else if (le) w = 1;
`endif
                end
                e_we   = (w == 0) ? cpu_we    : (w == 1) ? ldr_we    : 1'b0;
                e_addr = (w == 0) ? cpu_addr  : (w == 1) ? ldr_addr  : '0;
                e_wd   = (w == 0) ? cpu_wdata : (w == 1) ? ldr_wdata : '0;

                pfx = $sformatf("lat%0d cyc%0d ", LAT, n);
                check({pfx, "cpu_gnt"},   cpu_gnt,   w == 0);
                check({pfx, "ldr_gnt"},   ldr_gnt,   w == 1);
                check({pfx, "mem_en"},    mem_en,    w >= 0);
                check({pfx, "mem_we"},    mem_we,    e_we);
                check({pfx, "mem_addr"},  mem_addr,  e_addr);
                check({pfx, "mem_wdata"}, mem_wdata, e_wd);
                check({pfx, "busy"},      busy,      !rst && n < free_at);
                if (known) begin
                    check({pfx, "cpu_rvalid"}, cpu_rvalid, exp_rv[0]);
                    check({pfx, "ldr_rvalid"}, ldr_rvalid, exp_rv[1]);
                    check({pfx, "cpu_rdata"},  cpu_rdata,  exp_rd[0]);
                    check({pfx, "ldr_rdata"},  ldr_rdata,  exp_rd[1]);
                end

                // Advance the model across the coming rising edge.
                c_gp = (w == 0);
                l_gp = (w == 1);
                if (rst) begin
                    known     = 1'b1;
                    pend      = 1'b0;
                    free_at   = n + 1;
                    last_ldr  = 1'b1;
                    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
                    exp_rd[0] = '0;   exp_rd[1] = '0;
                end else begin
                    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
                    if (pend && n == cap_at) begin
                        pend = 1'b0;
                        exp_rv[p_ldr] = 1'b1;
                        if (!p_we) exp_rd[p_ldr] = mem_rdata;
                    end
                    if (w >= 0) begin
                        pend     = 1'b1;
                        p_ldr    = (w == 1);
                        p_we     = e_we;
                        cap_at   = n + int'(LAT);
                        free_at  = n + int'(LAT) + 1;
                        last_ldr = (w == 1);
                    end
                end
            end
            fin = 1'b1;
        end
    end

    initial begin
        fork
            wait (gen_cfg[0].fin && gen_cfg[1].fin);
            #(20 * NCYC * 10);
        join_any
        if (!(gen_cfg[0].fin && gen_cfg[1].fin)) begin
            check("run_timeout", 64'd0, 64'd1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
